uart_transceiver: RTL and testbench
===================================

# uart_transceiver

Full-duplex UART transceiver with an integrated programmable baud-tick generator, configurable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) and an oversampling receiver with parity and framing error reporting. It replaces the separate fixed-format `UartTx`/`UartRx` pair and their externally supplied `tick`. It sits between a register/bus front end (`tx_start`/`tx_data`, `rx_valid`/`rx_data`) and the serial pins.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5–9; sent LSB first.
- `PAR_MODE`, 0: 0 = no parity, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `DIV_W`, 16: width of `baud_div`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `baud_div`  in  DIV_W  tick period = `baud_div`+1 clk cycles; change only while both TX and RX are idle.
- `tx_start`  in  1  request to send `tx_data`; accepted only when `tx_busy`=0.
- `tx_data`  in  DATA_BITS  byte to transmit; sampled in the accept cycle.
- `tx`  out  1  serial output; idles high.
- `tx_busy`  out  1  high from the cycle after accept until `tx_done`.
- `tx_done`  out  1  one-cycle pulse at the end of the last stop bit.
- `rx`  in  1  serial input; asynchronous.
- `rx_data`  out  DATA_BITS  last received word; held until the next `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `rx_parity_err`  out  1  parity mismatch for the frame; updated with `rx_valid`, then held.
- `rx_frame_err`  out  1  a stop bit was sampled low; updated with `rx_valid`, then held.

## Operation
- **Baud generator**
  - Free-running counter 0..`baud_div`.
  - `tick` pulses one cycle when the counter equals `baud_div`; the counter then wraps to 0.
  - `baud_div`=0 gives a tick every cycle.
  - Shared by TX and RX.
- **TX FSM**: IDLE → START → DATA → PARITY (skipped if `PAR_MODE`=0) → STOP → IDLE.
  - Each bit lasts exactly `OVERSAMPLE` ticks, counted from the first tick after accept.
  - The start bit is driven from the cycle after accept, so it is up to one tick period longer.
  - Parity bit: XOR of the data bits, inverted for odd parity.
  - `tx_start` while busy is ignored; it does not queue.
- **RX front end**: 2-flop synchronizer on `rx`, both flops reset to 1.
- **RX FSM**: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE arms on a tick with the synchronized `rx` low.
  - START re-samples at tick `OVERSAMPLE`/2. If high, it is a false start: return to IDLE with no output.
  - DATA, PARITY and STOP sample the bit centre every `OVERSAMPLE` ticks thereafter.
  - Every stop bit is checked.
- **Frame completion**: on the tick that samples the last stop bit, the next cycle
  - updates `rx_data` and both error flags,
  - pulses `rx_valid`,
  - returns to IDLE (half-bit resync margin).
- **Error frames**
  - Data is delivered even with errors.
  - After a frame error, RX does not re-arm until the synchronized `rx` has been seen high (break handling).
  - With `PAR_MODE`=0, `rx_parity_err` is always 0.
- TX and RX are independent; simultaneous activity is fully supported.

## Timing
- Reset values:
  - `tx`=1; `tx_busy`=0; `tx_done`=0.
  - `rx_data`=0; `rx_valid`=0; `rx_parity_err`=0; `rx_frame_err`=0.
  - Baud counter = 0; all FSMs in IDLE.
- Reset mid-frame aborts both FSMs; `tx`=1 from the cycle after reset is sampled.
- Frame length N = 1 + `DATA_BITS` + (`PAR_MODE`≠0) + `STOP_BITS` bits.
- TX: `tx_done` occurs N·`OVERSAMPLE` ticks (+0/+1 tick) after accept.
  - `tx_busy` falls in the same cycle as `tx_done`.
  - The next `tx_start` is accepted from the following cycle.
- RX latency: 2 cycles of synchronizer plus sampling; `rx_valid` follows the cycle after the last stop-bit centre tick.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each RX bit value is the majority of three samples taken at ticks `OVERSAMPLE`/2−1, `OVERSAMPLE`/2 and `OVERSAMPLE`/2+1 of the bit. This applies to the start-bit check too.
- `UART_RX_MAJORITY_EN` undefined: each RX bit uses the single sample at tick `OVERSAMPLE`/2.
- Timing of `rx_valid` is identical in both builds.

## Test plan
- **Loopback 8N1**: `tx`→`rx`, `baud_div`=0, send 0x55.
  - `rx_data`=0x55; single `rx_valid` pulse; both error flags 0.
  - `tx_done` 160 (±1) cycles after accept.
- **Even parity**: send 0xA5 with `PAR_MODE`=1, then 0x07 with `PAR_MODE`=2.
  - Parity bits observed on `tx` are 0 (for 0xA5) and 0 (for 0x07).
  - With the parity bit forced inverted on `rx`: `rx_parity_err`=1 and the data is still correct.
- **Framing and break**: drive a frame with stop bit low, then hold `rx` low.
  - `rx_frame_err`=1 and `rx_valid` pulses once.
  - No further `rx_valid` until `rx` returns high and a new start bit arrives.
- **False start**: with `baud_div`=3, pulse `rx` low for 5 ticks.
  - No `rx_valid`; RX is back in IDLE and the next frame (0x3C) is received correctly.
- **TX handshake**: assert `tx_start` during a busy frame, then back-to-back requests.
  - The busy-time request is ignored.
  - Back-to-back sends of 0xFF then 0x00 each produce exactly one `tx_done`.
  - Reset asserted mid-frame gives `tx`=1 and `tx_busy`=0 the next cycle.
- **Glitch (with macro)**: inject a one-tick-wide inversion at each data-bit centre of 0x81.
  - With `UART_RX_MAJORITY_EN`: `rx_data`=0x81.
  - Without it: `rx_data`=0x7E.

Source files
------------

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with shared baud-tick generator; UART_RX_MAJORITY_EN enables 3-sample RX voting
module uart_transceiver #(
  parameter int DATA_BITS  = 8,
  parameter int PAR_MODE   = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1 + DLY);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam bit HAS_PAR = PAR_MODE != 0;
  localparam bit ODD     = PAR_MODE == 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [DIV_W-1:0] cnt_q;
  logic             tick;
  assign tick = cnt_q == baud_div;

  // free-running baud counter, wraps on tick
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + 1'b1;

  state_e                 tst_q, tst_d;
  logic [TW-1:0]          ttk_q, ttk_d;
  logic [BW-1:0]          tbit_q, tbit_d;
  logic [DATA_BITS-1:0]   tsh_q, tsh_d;
  logic                   tpar_q, tpar_d, tx_q, tx_d, tdone_q, tdone_d, tend;
  assign tend    = tick && ttk_q == T_LAST;
  assign tx      = tx_q;
  assign tx_busy = tst_q != IDLE;
  assign tx_done = tdone_q;

  // TX state register; the line itself is registered so it never glitches
  always_ff @(posedge clk)
    if (!rst_n) begin
      tst_q   <= IDLE;
      ttk_q   <= '0;
      tbit_q  <= '0;
      tsh_q   <= '0;
      tpar_q  <= 1'b0;
      tx_q    <= 1'b1;
      tdone_q <= 1'b0;
    end else begin
      tst_q   <= tst_d;
      ttk_q   <= ttk_d;
      tbit_q  <= tbit_d;
      tsh_q   <= tsh_d;
      tpar_q  <= tpar_d;
      tx_q    <= tx_d;
      tdone_q <= tdone_d;
    end

  // TX next state: each bit spans OVERSAMPLE ticks, line level derived from the next state
  always_comb begin
    tst_d   = tst_q;
    ttk_d   = ttk_q;
    tbit_d  = tbit_q;
    tsh_d   = tsh_q;
    tpar_d  = tpar_q;
    tdone_d = 1'b0;
    if (tst_q != IDLE && tick) ttk_d = tend ? '0 : ttk_q + 1'b1;
    case (tst_q)
      IDLE: if (tx_start) begin
        tst_d  = START;
        ttk_d  = '0;
        tsh_d  = tx_data;
        tpar_d = ^tx_data ^ ODD;
      end
      START: if (tend) begin
        tst_d  = DATA;
        tbit_d = '0;
      end
      DATA: if (tend) begin
        tsh_d  = tsh_q >> 1;
        tbit_d = tbit_q + 1'b1;
        if (tbit_q == D_LAST) begin
          tst_d  = HAS_PAR ? PARITY : STOP;
          tbit_d = '0;
        end
      end
      PARITY: if (tend) tst_d = STOP;
      STOP: if (tend) begin
        tbit_d = tbit_q + 1'b1;
        if (tbit_q == S_LAST) begin
          tst_d   = IDLE;
          tdone_d = 1'b1;
        end
      end
      default: tst_d = IDLE;
    endcase
    tx_d = tst_d == START ? 1'b0 : tst_d == DATA ? tsh_d[0] : tst_d == PARITY ? tpar_d : 1'b1;
  end

  state_e               rst_q, rst_d;
  logic [TW-1:0]        rtk_q, rtk_d;
  logic [BW-1:0]        rbit_q, rbit_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d, rdata_q, rdata_d;
  logic                 s1_q, s2_q, pacc_q, pacc_d, facc_q, facc_d, brk_q, brk_d;
  logic                 rvalid_q, rvalid_d, rperr_q, rperr_d, rferr_q, rferr_d;
  logic                 rdec, bv;
  assign rdec          = tick && rtk_q == (rst_q == START ? T_MID : T_LAST);
  assign rx_data       = rdata_q;
  assign rx_valid      = rvalid_q;
  assign rx_parity_err = rperr_q;
  assign rx_frame_err  = rferr_q;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] win_q;
  assign bv = (win_q[1] & win_q[0]) | (win_q[1] & s2_q) | (win_q[0] & s2_q);

  // per-tick sample history; the vote completes on the tick after the bit centre
  always_ff @(posedge clk)
    if (!rst_n) win_q <= 2'b11;
    else if (tick) win_q <= {win_q[0], s2_q};
`else
  assign bv = s2_q;
`endif

  // RX synchronizer and state register
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      rst_q    <= IDLE;
      rtk_q    <= '0;
      rbit_q   <= '0;
      rsh_q    <= '0;
      pacc_q   <= 1'b0;
      facc_q   <= 1'b0;
      brk_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rperr_q  <= 1'b0;
      rferr_q  <= 1'b0;
    end else begin
      s1_q     <= rx;
      s2_q     <= s1_q;
      rst_q    <= rst_d;
      rtk_q    <= rtk_d;
      rbit_q   <= rbit_d;
      rsh_q    <= rsh_d;
      pacc_q   <= pacc_d;
      facc_q   <= facc_d;
      brk_q    <= brk_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rperr_q  <= rperr_d;
      rferr_q  <= rferr_d;
    end

  // RX next state: arm on low, confirm at start centre, then sample every OVERSAMPLE ticks
  always_comb begin
    rst_d    = rst_q;
    rtk_d    = rtk_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    pacc_d   = pacc_q;
    facc_d   = facc_q;
    brk_d    = brk_q & ~s2_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rperr_d  = rperr_q;
    rferr_d  = rferr_q;
    if (rst_q != IDLE && tick) rtk_d = rdec ? '0 : rtk_q + 1'b1;
    case (rst_q)
      IDLE: if (tick && !s2_q && !brk_q) begin
        rst_d = START;
        rtk_d = '0;
      end
      START: if (rdec) begin
        rst_d  = bv ? IDLE : DATA;
        rbit_d = '0;
        pacc_d = ODD;
        facc_d = 1'b0;
      end
      DATA: if (rdec) begin
        rsh_d  = {bv, rsh_q[DATA_BITS-1:1]};
        pacc_d = pacc_q ^ bv;
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == D_LAST) begin
          rst_d  = HAS_PAR ? PARITY : STOP;
          rbit_d = '0;
        end
      end
      PARITY: if (rdec) begin
        pacc_d = pacc_q ^ bv;
        rst_d  = STOP;
      end
      STOP: if (rdec) begin
        facc_d = facc_q | ~bv;
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == S_LAST) begin
          rst_d    = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = rsh_q;
          rperr_d  = HAS_PAR && pacc_q;
          rferr_d  = facc_d;
          brk_d    = facc_d;
        end
      end
      default: rst_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed checks of 8N1, 8E1 and 8O1 transceivers sharing one TX request bus
module tb_uart_transceiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tx_start, lb, flip, flip_en, rx_drv;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_n, busy_n, done_n, rx_n, valid_n, perr_n, ferr_n;
  logic        tx_e, busy_e, done_e, rx_e, valid_e, perr_e, ferr_e;
  logic        tx_o, busy_o, done_o, rx_o, valid_o, perr_o, ferr_o;
  logic [7:0]  data_n, data_e, data_o;

  assign rx_n = lb ? tx_n : rx_drv;
  assign rx_e = tx_e ^ flip;
  assign rx_o = tx_o;

  uart_transceiver u_n (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_n), .tx_busy(busy_n), .tx_done(done_n), .rx(rx_n), .rx_data(data_n),
    .rx_valid(valid_n), .rx_parity_err(perr_n), .rx_frame_err(ferr_n));

  uart_transceiver #(.PAR_MODE(1)) u_e (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e), .rx(rx_e), .rx_data(data_e),
    .rx_valid(valid_e), .rx_parity_err(perr_e), .rx_frame_err(ferr_e));

  uart_transceiver #(.PAR_MODE(2)) u_o (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o), .rx(rx_o), .rx_data(data_o),
    .rx_valid(valid_o), .rx_parity_err(perr_o), .rx_frame_err(ferr_o));

  int n_chk = 0, n_fail = 0;
  int dn_cnt = 0, vn_cnt = 0, ve_cnt = 0, vo_cnt = 0;
  int lat_n, lat_e, v0, d0;
  logic tr_n [0:299];
  logic tr_e [0:299];
  logic tr_o [0:299];

  always @(negedge clk) begin
    if (done_n) dn_cnt++;
    if (valid_n) vn_cnt++;
    if (valid_e) ve_cnt++;
    if (valid_o) vo_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // issues one request at the current negedge; trace index c = negedges after accept
  task automatic send_frame(input logic [7:0] d, input int maxc, input bit early, input bit poke);
    int c;
    c = 0;
    lat_n = 0;
    lat_e = 0;
    tx_start = 1'b1;
    tx_data = d;
    while (c < maxc && !(early && lat_n != 0)) begin
      @(negedge clk);
      c++;
      tx_start = poke && c == 50;
      if (poke && c == 50) tx_data = 8'h12;
      flip = flip_en && c >= 146 && c < 158;
      if (c < 300) begin
        tr_n[c] = tx_n;
        tr_e[c] = tx_e;
        tr_o[c] = tx_o;
      end
      if (done_n && lat_n == 0) lat_n = c;
      if (done_e && lat_e == 0) lat_e = c;
    end
    tx_start = 1'b0;
    flip = 1'b0;
  endtask

  function automatic logic [7:0] word_n();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = tr_n[16 * (i + 1) + 8];
    return w;
  endfunction

  task automatic rx_frame(input logic [7:0] d, input logic stopv, input int bl, input bit gl);
    int b;
    logic v;
    for (int c = 0; c < 10 * bl; c++) begin
      @(negedge clk);
      b = c / bl;
      v = b == 0 ? 1'b0 : b <= 8 ? d[b-1] : stopv;
      if (gl && b >= 1 && b <= 8 && c % bl == bl / 2) v = ~v;
      rx_drv = v;
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_start = 1'b0; tx_data = '0; lb = 1'b1;
    flip = 1'b0; flip_en = 1'b0; rx_drv = 1'b1; baud_div = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_n, 1);
    check("rst_busy", busy_n, 0);
    check("rst_done", done_n, 0);
    check("rst_rx_data", data_n, 0);
    check("rst_rx_valid", valid_n, 0);
    check("rst_perr", perr_n, 0);
    check("rst_ferr", ferr_n, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    v0 = vn_cnt;
    send_frame(8'h55, 230, 0, 0);
    check("lat_8n1", lat_n >= 160 && lat_n <= 162, 1);
    check("tx_start_bit", tr_n[8], 0);
    check("tx_word_55", word_n(), 8'h55);
    check("tx_stop_bit", tr_n[152], 1);
    check("lb_valid_cnt", vn_cnt - v0, 1);
    check("lb_data_55", data_n, 8'h55);
    check("lb_perr", perr_n, 0);
    check("lb_ferr", ferr_n, 0);
    check("lat_8e1", lat_e >= 176 && lat_e <= 178, 1);

    flip_en = 1'b1;
    v0 = ve_cnt;
    send_frame(8'hA5, 230, 0, 0);
    flip_en = 1'b0;
    check("par_a5_even", tr_e[152], 0);
    check("par_a5_odd", tr_o[152], 1);
    check("flip_valid_cnt", ve_cnt - v0, 1);
    check("flip_perr", perr_e, 1);
    check("flip_data", data_e, 8'hA5);
    check("flip_ferr", ferr_e, 0);

    v0 = vo_cnt;
    send_frame(8'h07, 230, 0, 0);
    check("par_07_odd", tr_o[152], 0);
    check("odd_valid_cnt", vo_cnt - v0, 1);
    check("odd_data", data_o, 8'h07);
    check("odd_perr", perr_o, 0);
    check("even_perr_clr", perr_e, 0);

    d0 = dn_cnt; v0 = vn_cnt;
    send_frame(8'hFF, 230, 0, 1);
    check("busy_req_done_cnt", dn_cnt - d0, 1);
    check("busy_req_idle", busy_n, 0);
    check("busy_req_data", data_n, 8'hFF);
    check("busy_req_valid_cnt", vn_cnt - v0, 1);

    d0 = dn_cnt;
    send_frame(8'hFF, 300, 1, 0);
    check("b2b_ff_word", word_n(), 8'hFF);
    @(negedge clk);
    send_frame(8'h00, 300, 1, 0);
    repeat (5) @(negedge clk);
    check("b2b_done_cnt", dn_cnt - d0, 2);
    check("b2b_00_word", word_n(), 8'h00);
    check("b2b_00_data", data_n, 8'h00);

    send_frame(8'h33, 60, 0, 0);
    check("mid_busy", busy_n, 1);
    check("mid_tx", tx_n, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", tx_n, 1);
    check("mid_rst_busy", busy_n, 0);
    check("mid_rst_rx_data", data_n, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    lb = 1'b0;
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    v0 = vn_cnt;
    rx_frame(8'h5A, 1'b0, 16, 0);
    repeat (300) @(negedge clk);
    check("brk_valid_cnt", vn_cnt - v0, 1);
    check("brk_ferr", ferr_n, 1);
    check("brk_data", data_n, 8'h5A);
    check("brk_perr", perr_n, 0);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rx_frame(8'hC3, 1'b1, 16, 0);
    repeat (10) @(negedge clk);
    check("rearm_valid_cnt", vn_cnt - v0, 2);
    check("rearm_ferr", ferr_n, 0);
    check("rearm_data", data_n, 8'hC3);

    rx_frame(8'h81, 1'b1, 16, 1);
    repeat (10) @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
    check("glitch_data", data_n, 8'h81);
`else
    check("glitch_data", data_n, 8'h7E);
`endif

    baud_div = 16'd3;
    repeat (10) @(negedge clk);
    v0 = vn_cnt;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    check("false_start_valid_cnt", vn_cnt - v0, 0);
    rx_frame(8'h3C, 1'b1, 64, 0);
    repeat (20) @(negedge clk);
    check("after_false_valid_cnt", vn_cnt - v0, 1);
    check("after_false_data", data_n, 8'h3C);
    check("after_false_ferr", ferr_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
